// File: rtl/aes_decipher_iter.sv
// -----------------------------------------------------------------------------
// aes_decipher_iter
// Iterative AES inverse cipher for AES-128/192/256. A key is loaded once and
// expanded one 32-bit word per clock into an on-chip round-key store. Blocks
// are then decrypted at one round per clock.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. Producers may drop or change data after the transfer edge. dataout and
// out_valid are held stable until the consumer takes the block.
//
// Ports
//   clk, rst     clock and asynchronous active-high reset
//   key_valid    key_in valid; key_ready high in IDLE and READY only
//   key_in       cipher key, word w[0] in the MSBs
//   in_valid     datain valid; in_ready = READY && !key_valid
//   datain       ciphertext block, byte 0 in [127:120]
//   out_valid    dataout valid, held until out_ready
//   out_ready    consumer accepts dataout
//   dataout      plaintext block, same byte order as datain
//   key_loaded   round-key store complete and valid
//   dbg_state_o  current FSM state
// -----------------------------------------------------------------------------
module aes_decipher_iter #(
  parameter int KEY_BITS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        datain,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        dataout,
  output logic                key_loaded,
  output logic [2:0]          dbg_state_o
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_decipher_iter: KEY_BITS must be 128, 192 or 256");
  end

  // GF(2^8) arithmetic, reduction polynomial 0x11b. The S-boxes are built from
  // the field inverse plus the affine map instead of lookup tables.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // a^254 = a^-1 (and 0 -> 0): accumulate a^2 * a^4 * ... * a^128.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int k = 0; k < 7; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte n of the block is row n%4, column n/4. Row r rotates right by r.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0,8'h0e) ^ gf_mul(a1,8'h0b) ^ gf_mul(a2,8'h0d) ^ gf_mul(a3,8'h09);
      o[119-32*c -: 8] = gf_mul(a0,8'h09) ^ gf_mul(a1,8'h0e) ^ gf_mul(a2,8'h0b) ^ gf_mul(a3,8'h0d);
      o[111-32*c -: 8] = gf_mul(a0,8'h0d) ^ gf_mul(a1,8'h09) ^ gf_mul(a2,8'h0e) ^ gf_mul(a3,8'h0b);
      o[103-32*c -: 8] = gf_mul(a0,8'h0b) ^ gf_mul(a1,8'h0d) ^ gf_mul(a2,8'h09) ^ gf_mul(a3,8'h0e);
    end
    return o;
  endfunction

  typedef enum logic [2:0] {IDLE, KEYEXP, READY, ROUND, DONE} state_t;

  state_t       state_q;
  logic [31:0]  w_q [NW];
  logic [31:0]  w_d [NW];
  logic [5:0]   i_q;          // index of the word being expanded
  logic [2:0]   kmod_q;       // i_q % NK, tracked incrementally
  logic [7:0]   rcon_q;
  logic [3:0]   r_q;          // round key used by the current ROUND cycle
  logic [127:0] data_q;
  logic [127:0] dout_q;
  logic         out_valid_q;
  logic         key_loaded_q;

  logic         key_acc;
  logic [31:0]  word_d;
  logic [3:0]   rk_sel;
  logic [127:0] rk;
  logic [127:0] sub_d;
  logic [127:0] round_d;

  assign key_ready   = !rst && (state_q == IDLE || state_q == READY);
  assign in_ready    = (state_q == READY) && !key_valid;
  assign key_acc     = key_valid && key_ready;
  assign out_valid   = out_valid_q;
  assign dataout     = dout_q;
  assign key_loaded  = key_loaded_q;
  assign dbg_state_o = state_q;

  // Next expanded word w[i] from w[i-1] and w[i-NK].
  always_comb begin
    logic [5:0]  prev_idx, back_idx;
    logic [31:0] temp;
    prev_idx = i_q - 6'd1;
    back_idx = i_q - 6'(NK);
    temp     = w_q[prev_idx];
    if (kmod_q == 3'd0)
      temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon_q, 24'h000000};
    else if (NK == 8 && kmod_q == 3'd4)
      temp = sub_word(temp);
    word_d = w_q[back_idx] ^ temp;
  end

  always_comb begin
    w_d = w_q;
    if (key_acc) begin
      for (int j = 0; j < NK; j++) w_d[j] = key_in[KEY_BITS-1-32*j -: 32];
    end else if (state_q == KEYEXP) begin
      w_d[i_q] = word_d;
    end
  end

  // Outside ROUND the selector points at rk[NR], the whitening key for accept.
  always_comb begin
    rk_sel  = (state_q == ROUND) ? r_q : 4'(NR);
    rk      = {w_q[{rk_sel, 2'b00}], w_q[{rk_sel, 2'b01}],
               w_q[{rk_sel, 2'b10}], w_q[{rk_sel, 2'b11}]};
    sub_d   = inv_shift_sub(data_q) ^ rk;
    round_d = (r_q == 4'd0) ? sub_d : inv_mix_columns(sub_d);
  end

  // The key store needs no reset: its contents only matter once key_loaded is set.
  always_ff @(posedge clk) begin
    w_q <= w_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      i_q          <= '0;
      kmod_q       <= '0;
      rcon_q       <= 8'h01;
      r_q          <= '0;
      data_q       <= '0;
      dout_q       <= '0;
      out_valid_q  <= 1'b0;
      key_loaded_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_valid) begin
            state_q <= KEYEXP;
            i_q     <= 6'(NK);
            kmod_q  <= '0;
            rcon_q  <= 8'h01;
          end
        end
        KEYEXP: begin
          i_q    <= i_q + 6'd1;
          kmod_q <= (kmod_q == 3'(NK - 1)) ? 3'd0 : kmod_q + 3'd1;
          if (kmod_q == 3'd0) rcon_q <= xtime(rcon_q);
          if (i_q == 6'(NW - 1)) begin
            key_loaded_q <= 1'b1;
            state_q      <= READY;
          end
        end
        READY: begin
          if (key_valid) begin
            // A new key always wins over a pending block.
            key_loaded_q <= 1'b0;
            state_q      <= KEYEXP;
            i_q          <= 6'(NK);
            kmod_q       <= '0;
            rcon_q       <= 8'h01;
          end else if (in_valid) begin
            data_q  <= datain ^ rk;
            r_q     <= 4'(NR - 1);
            state_q <= ROUND;
          end
        end
        ROUND: begin
          data_q <= round_d;
          if (r_q == 4'd0) begin
            dout_q      <= round_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            r_q <= r_q - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= READY;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_decipher_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_decipher_iter
// Three instances (AES-128/192/256) share the key and data buses and have their
// own handshake lines. Expected plaintexts come from a forward-cipher model:
// a random plaintext is encrypted by the model and the DUT must recover it.
// -----------------------------------------------------------------------------
module tb_aes_decipher_iter;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [255:0] key_bus;
  logic [127:0] datain;
  logic         key_valid [3];
  logic         in_valid  [3];
  logic         out_ready [3];
  logic         key_ready [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         key_loaded[3];
  logic [127:0] dataout   [3];
  logic [2:0]   dbg_state [3];

  aes_decipher_iter #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst(rst), .key_valid(key_valid[0]), .key_ready(key_ready[0]),
    .key_in(key_bus[255:128]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .datain(datain), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .dataout(dataout[0]), .key_loaded(key_loaded[0]), .dbg_state_o(dbg_state[0]));

  aes_decipher_iter #(.KEY_BITS(192)) u_dut192 (
    .clk(clk), .rst(rst), .key_valid(key_valid[1]), .key_ready(key_ready[1]),
    .key_in(key_bus[255:64]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .datain(datain), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .dataout(dataout[1]), .key_loaded(key_loaded[1]), .dbg_state_o(dbg_state[1]));

  aes_decipher_iter #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst(rst), .key_valid(key_valid[2]), .key_ready(key_ready[2]),
    .key_in(key_bus), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .datain(datain), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .dataout(dataout[2]), .key_loaded(key_loaded[2]), .dbg_state_o(dbg_state[2]));

  // ---------------- scoreboard state ----------------
  int           n_cmp = 0;
  int           n_mis = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   sbox[256];
  logic [31:0]  mw[60];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nk_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 6 : 8;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from walking the multiplicative group with generator 3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int it = 0; it < 255; it++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end
    sbox[0] = 8'h63;
  endtask

  function automatic logic [31:0] m_sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) mw[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = m_sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = m_sub_word(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input int nk);
    logic [7:0]   s[4][4];
    logic [7:0]   t[4][4];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] ct;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ mw[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= nk + 6; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbox[s[r][(c+r)%4]];
      if (rnd != nk + 6) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[0][c]; a1 = t[1][c]; a2 = t[2][c]; a3 = t[3][c];
          s[0][c] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[1][c] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[2][c] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[3][c] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end else begin
        s = t;
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = s[r][c] ^ mw[4*rnd+c][31-8*r -: 8];
    end
    ct = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        ct[127-8*(4*c+r) -: 8] = s[r][c];
    return ct;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic key_accept(input int k, input logic [255:0] key);
    int n = 0;
    key_bus      = key;
    key_valid[k] = 1'b1;
    #1;
    while (!key_ready[k] && n < 200) begin step(); n++; end
    if (n >= 200) check_eq("key_ready_timeout", 128'(key_ready[k]), 128'd1);
    step();
    key_valid[k] = 1'b0;
  endtask

  task automatic key_wait(input int k);
    int n = 0;
    check_eq("key_loaded_drop", 128'(key_loaded[k]), 128'd0);
    check_eq("key_ready_busy", 128'(key_ready[k]), 128'd0);
    while (!key_loaded[k] && n < 100) begin step(); n++; end
    check_eq("keyexp_cycles", 128'(n), 128'(4 * (nk_of(k) + 7) - nk_of(k)));
    check_eq("key_ready_after", 128'(key_ready[k]), 128'd1);
  endtask

  task automatic accept_block(input int k, input logic [127:0] ct);
    int n = 0;
    datain      = ct;
    in_valid[k] = 1'b1;
    #1;
    while (!in_ready[k] && n < 200) begin step(); n++; end
    if (n >= 200) check_eq("in_ready_timeout", 128'(in_ready[k]), 128'd1);
    step();
    in_valid[k] = 1'b0;
  endtask

  task automatic random_block(input int k);
    logic [127:0] pt;
    pt = rand128();
    accept_block(k, model_encrypt(pt, nk_of(k)));
    exp_q.push_back(pt);
  endtask

  task automatic wait_out(input int k);
    int n = 0;
    while (!out_valid[k] && n < 40) begin step(); n++; end
    check_eq("latency", 128'(n), 128'(nk_of(k) + 6));
    check_eq("sb_depth", 128'(exp_q.size()), 128'd1);
    if (exp_q.size() > 0) check_eq("dataout", dataout[k], exp_q[0]);
  endtask

  task automatic release_out(input int k);
    out_ready[k] = 1'b1;
    step();
    out_ready[k] = 1'b0;
    check_eq("out_valid_drop", 128'(out_valid[k]), 128'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic collect(input int k, input int hold);
    wait_out(k);
    for (int h = 0; h < hold; h++) begin
      step();
      check_eq("hold_valid", 128'(out_valid[k]), 128'd1);
      if (exp_q.size() > 0) check_eq("hold_data", dataout[k], exp_q[0]);
    end
    release_out(k);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY_128 = {128'h000102030405060708090a0b0c0d0e0f, 128'd0};
  localparam logic [255:0] KEY_192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'd0};
  localparam logic [255:0] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no end, expected finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] k2;
    logic [127:0] pts[4];
    build_sbox();
    rst = 1'b1; key_bus = '0; datain = '0;
    for (int k = 0; k < 3; k++) begin
      key_valid[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
    end
    step(); step();
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_key_ready", 128'(key_ready[k]), 128'd0);
      check_eq("rst_in_ready", 128'(in_ready[k]), 128'd0);
      check_eq("rst_out_valid", 128'(out_valid[k]), 128'd0);
      check_eq("rst_dataout", dataout[k], 128'd0);
      check_eq("rst_key_loaded", 128'(key_loaded[k]), 128'd0);
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq("idle_key_ready", 128'(key_ready[k]), 128'd1);
      check_eq("idle_in_ready", 128'(in_ready[k]), 128'd0);
    end

    // Model sanity against the FIPS-197 known answers.
    model_expand(KEY_128, 4); check_eq("model_128", model_encrypt(PT_FIPS, 4), CT_128);
    model_expand(KEY_192, 6); check_eq("model_192", model_encrypt(PT_FIPS, 6), CT_192);
    model_expand(KEY_256, 8); check_eq("model_256", model_encrypt(PT_FIPS, 8), CT_256);

    // T1 / T2 / T3 known-answer decryptions.
    key_accept(0, KEY_128); key_wait(0);
    accept_block(0, CT_128); exp_q.push_back(PT_FIPS); collect(0, 2);
    key_accept(1, KEY_192); key_wait(1);
    accept_block(1, CT_192); exp_q.push_back(PT_FIPS); collect(1, 0);
    key_accept(2, KEY_256); key_wait(2);
    accept_block(2, CT_256); exp_q.push_back(PT_FIPS); collect(2, 1);

    // T3 back-to-back: the next block is already offered while out_ready is held low.
    model_expand(KEY_256, 8);
    for (int b = 0; b < 4; b++) pts[b] = rand128();
    accept_block(2, model_encrypt(pts[0], 8));
    exp_q.push_back(pts[0]);
    for (int b = 0; b < 4; b++) begin
      wait_out(2);
      if (b < 3) begin
        datain      = model_encrypt(pts[b+1], 8);
        in_valid[2] = 1'b1;
      end
      for (int h = 0; h < 5; h++) begin
        step();
        check_eq("b2b_valid", 128'(out_valid[2]), 128'd1);
        check_eq("b2b_in_ready", 128'(in_ready[2]), 128'd0);
        if (exp_q.size() > 0) check_eq("b2b_data", dataout[2], exp_q[0]);
      end
      release_out(2);
      if (b < 3) begin
        check_eq("b2b_ready_again", 128'(in_ready[2]), 128'd1);
        step();
        in_valid[2] = 1'b0;
        exp_q.push_back(pts[b+1]);
      end
    end

    // Random keys and blocks on every key size.
    for (int k = 0; k < 3; k++) begin
      for (int rep = 0; rep < 2; rep++) begin
        k2 = rand256();
        key_accept(k, k2); key_wait(k);
        model_expand(k2, nk_of(k));
        for (int b = 0; b < 3; b++) begin
          random_block(k);
          collect(k, $urandom_range(0, 3));
        end
      end
    end

    // T4: key and block offered together in READY; the key wins.
    k2           = rand256();
    key_bus      = k2;
    datain       = rand128();
    key_valid[2] = 1'b1;
    in_valid[2]  = 1'b1;
    #1;
    check_eq("t4_in_ready", 128'(in_ready[2]), 128'd0);
    check_eq("t4_key_ready", 128'(key_ready[2]), 128'd1);
    step();
    key_valid[2] = 1'b0;
    in_valid[2]  = 1'b0;
    key_wait(2);
    check_eq("t4_no_output", 128'(out_valid[2]), 128'd0);
    model_expand(k2, 8);
    random_block(2); collect(2, 1);

    // T5: reset during the fifth ROUND cycle.
    accept_block(0, rand128());
    repeat (4) step();
    rst = 1'b1;
    #1;
    check_eq("t5_out_valid", 128'(out_valid[0]), 128'd0);
    check_eq("t5_key_loaded", 128'(key_loaded[0]), 128'd0);
    check_eq("t5_key_ready_rst", 128'(key_ready[0]), 128'd0);
    step();
    rst = 1'b0;
    #1;
    check_eq("t5_key_ready", 128'(key_ready[0]), 128'd1);
    check_eq("t5_in_ready", 128'(in_ready[0]), 128'd0);
    datain      = CT_128;
    in_valid[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("t5_no_accept", 128'(in_ready[0]), 128'd0);
      check_eq("t5_no_output", 128'(out_valid[0]), 128'd0);
    end
    in_valid[0] = 1'b0;
    key_accept(0, KEY_128); key_wait(0);
    accept_block(0, CT_128); exp_q.push_back(PT_FIPS); collect(0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
